// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite sequencer.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } mouth_t;

  // Sprite edge in pixels; equals the height of one ROM frame.
  localparam logic [9:0]  SPRITE_SIZE  = 10'd16;
  localparam logic [2:0]  FRAME_CLOSED = 3'd0;
  localparam logic [11:0] FRAME_ROWS   = 12'd16;

  // Open-mouth frames follow the closed frame in direction order.
  function automatic logic [2:0] open_frame(input dir_t dir);
    return {1'b0, dir} + 3'd1;
  endfunction

endpackage

// File: rtl/pacman_anim_fsm.sv
// Per-video-frame state: latched direction/motion, mouth FSM and frame select.
module pacman_anim_fsm #(
  parameter int unsigned ANIM_PERIOD = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic [1:0] dir_req_i,
  input  logic       moving_i,
  output logic [2:0] frame_sel_o
);
  import pacman_pkg::*;

  localparam logic [7:0] LAST_COUNT = 8'(ANIM_PERIOD - 1);

  dir_t       dir_q;
  logic       moving_q;
  mouth_t     state_q;
  logic [7:0] anim_cnt_q;
  logic [2:0] frame_sel_q;
  dir_t       dir_new;
  logic [2:0] unused_latched;

  // The tick-cycle request is used directly, so the latched copies only
  // carry state for observation between ticks.
  assign dir_new        = dir_t'(dir_req_i);
  assign unused_latched = {moving_q, dir_q};
  assign frame_sel_o    = frame_sel_q;

  // Once per video frame: latch inputs, advance the mouth FSM, pick the frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dir_q       <= RIGHT;
      moving_q    <= 1'b0;
      state_q     <= CLOSED;
      anim_cnt_q  <= '0;
      frame_sel_q <= FRAME_CLOSED;
    end else if (frame_tick_i) begin
      dir_q    <= dir_new;
      moving_q <= moving_i;
      if (!moving_i) begin
        state_q     <= OPEN;
        anim_cnt_q  <= '0;
        frame_sel_q <= open_frame(dir_new);
      end else if (anim_cnt_q == LAST_COUNT) begin
        anim_cnt_q <= '0;
        if (state_q == CLOSED) begin
          state_q     <= OPEN;
          frame_sel_q <= open_frame(dir_new);
        end else begin
          state_q     <= CLOSED;
          frame_sel_q <= FRAME_CLOSED;
        end
      end else begin
        anim_cnt_q  <= anim_cnt_q + 8'd1;
        frame_sel_q <= (state_q == OPEN) ? open_frame(dir_new) : FRAME_CLOSED;
      end
    end
  end

endmodule

// File: rtl/pacman_sprite_ctrl.sv
// Pac-Man sprite sequencer: hit test, ROM addressing and 2-stage pixel pipeline.
module pacman_sprite_ctrl #(
  parameter int unsigned ANIM_PERIOD = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic [1:0]  dir_req_i,
  input  logic        moving_i,
  input  logic [9:0]  pac_x_i,
  input  logic [9:0]  pac_y_i,
  input  logic [9:0]  draw_x_i,
  input  logic [9:0]  draw_y_i,
  input  logic        draw_valid_i,
  output logic [11:0] rom_addr_o,
  input  logic [16:0] rom_data_i,
  output logic [2:0]  frame_sel_o,
  output logic        pixel_on_o,
  output logic        pixel_valid_o
);
  import pacman_pkg::*;

  logic [2:0]  frame_sel;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic        hit;
  logic [11:0] rom_addr_d;
  logic [11:0] rom_addr_q;
  logic [3:0]  col_q;
  logic        hit_q;
  logic        valid_q;
  logic        pixel_on_q;
  logic        pixel_valid_q;
  logic [15:0] row_bits;
  logic        unused_rom_msb;

  pacman_anim_fsm #(
    .ANIM_PERIOD(ANIM_PERIOD)
  ) u_anim (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .frame_tick_i(frame_tick_i),
    .dir_req_i   (dir_req_i),
    .moving_i    (moving_i),
    .frame_sel_o (frame_sel)
  );

  // Modulo-1024 offsets: a pixel left of or above the sprite wraps to a
  // large value and fails the range test.
  assign dx  = draw_x_i - pac_x_i;
  assign dy  = draw_y_i - pac_y_i;
  assign hit = draw_valid_i && (dx < SPRITE_SIZE) && (dy < SPRITE_SIZE);

  assign rom_addr_d = hit ? ({9'd0, frame_sel} * FRAME_ROWS + {8'd0, dy[3:0]})
                          : 12'd0;

  // Bit 15 is the leftmost pixel; bit 16 of the ROM word carries nothing.
  assign row_bits       = rom_data_i[15:0];
  assign unused_rom_msb = rom_data_i[16];

  assign rom_addr_o    = rom_addr_q;
  assign frame_sel_o   = frame_sel;
  assign pixel_on_o    = pixel_on_q;
  assign pixel_valid_o = pixel_valid_q;

  // Stage 1: register the ROM address and carry column/hit/valid alongside.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rom_addr_q <= '0;
      col_q      <= '0;
      hit_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      col_q      <= dx[3:0];
      hit_q      <= hit;
      valid_q    <= draw_valid_i;
    end
  end

  // Stage 2: pick the column bit out of the ROM row returned for stage 1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pixel_on_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_on_q    <= hit_q & row_bits[~col_q];
      pixel_valid_q <= valid_q;
    end
  end

endmodule

// File: tb/tb_pacman_sprite_ctrl.sv
// Scoreboard testbench for pacman_sprite_ctrl with a behavioural sprite model.
module tb_pacman_sprite_ctrl;

  localparam int ANIM_PERIOD = 8;

  logic        clk;
  logic        reset;
  logic        frameTick;
  logic [1:0]  dirReq;
  logic        moving;
  logic [9:0]  pacX;
  logic [9:0]  pacY;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        drawValid;
  logic [11:0] romAddr;
  logic [16:0] romData;
  logic [2:0]  frameSel;
  logic        pixelOn;
  logic        pixelValid;

  bit [16:0] romModel [128];

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  fsel;
  } cycExp_t;

  typedef struct {
    logic pix;
    int   due;
  } pixExp_t;

  cycExp_t cycQ[$];
  pixExp_t pixQ[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int drvEdge = 0;

  // Reference state: mouth open flag, tick counter within a phase, direction.
  int mOpen = 0;
  int mCnt  = 0;
  int mDir  = 3;
  int mFsel = 0;

  pacman_sprite_ctrl #(
    .ANIM_PERIOD(ANIM_PERIOD)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frameTick),
    .dir_req_i    (dirReq),
    .moving_i     (moving),
    .pac_x_i      (pacX),
    .pac_y_i      (pacY),
    .draw_x_i     (drawX),
    .draw_y_i     (drawY),
    .draw_valid_i (drawValid),
    .rom_addr_o   (romAddr),
    .rom_data_i   (romData),
    .frame_sel_o  (frameSel),
    .pixel_on_o   (pixelOn),
    .pixel_valid_o(pixelValid)
  );

  // Combinational sprite ROM standing in for pacman_data.
  assign romData = romModel[romAddr[6:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs, record what the DUT must answer, wait the edge.
  task automatic applyStimulus(input bit rst, input bit tick, input bit [1:0] dir,
                               input bit mov, input bit [9:0] px, input bit [9:0] py,
                               input bit [9:0] dxp, input bit [9:0] dyp, input bit dv);
    int      dxv;
    int      dyv;
    bit      hit;
    int      addr;
    pixExp_t p;
    cycExp_t c;
    reset     = rst;
    frameTick = tick;
    dirReq    = dir;
    moving    = mov;
    pacX      = px;
    pacY      = py;
    drawX     = dxp;
    drawY     = dyp;
    drawValid = dv;
    drvEdge++;
    if (rst) begin
      pixQ.delete();
      mOpen  = 0;
      mCnt   = 0;
      mDir   = 3;
      mFsel  = 0;
      c.addr = '0;
      c.fsel = '0;
    end else begin
      dxv  = (int'(dxp) - int'(px)) & 1023;
      dyv  = (int'(dyp) - int'(py)) & 1023;
      hit  = dv && (dxv < 16) && (dyv < 16);
      addr = hit ? (mFsel * 16 + dyv) : 0;
      if (dv) begin
        p.pix = hit ? romModel[addr][15 - dxv] : 1'b0;
        p.due = drvEdge + 1;
        pixQ.push_back(p);
      end
      if (tick) begin
        mDir = int'(dir);
        if (!mov) begin
          mOpen = 1;
          mCnt  = 0;
        end else if (mCnt == ANIM_PERIOD - 1) begin
          mOpen = 1 - mOpen;
          mCnt  = 0;
        end else begin
          mCnt++;
        end
        mFsel = (mOpen != 0) ? (1 + mDir) : 0;
      end
      c.addr = 12'(addr);
      c.fsel = 3'(mFsel);
    end
    cycQ.push_back(c);
    @(negedge clk);
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard queues.
  initial begin
    cycExp_t c;
    pixExp_t p;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cycQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL cycle_queue: actual=empty required=entry (cycle %0d)", cyc);
      end else begin
        c = cycQ.pop_front();
        checkOutput("rom_addr", 32'(romAddr), 32'(c.addr));
        checkOutput("frame_sel", 32'(frameSel), 32'(c.fsel));
      end
      if (pixQ.size() > 0 && pixQ[0].due <= cyc) begin
        p = pixQ.pop_front();
        checkOutput("pixel_valid", 32'(pixelValid), 32'd1);
        checkOutput("pixel_on", 32'(pixelOn), 32'(p.pix));
      end else begin
        checkOutput("idle_pixel_valid", 32'(pixelValid), 32'd0);
        checkOutput("idle_pixel_on", 32'(pixelOn), 32'd0);
      end
    end
  end

  initial begin
    int px;
    int py;
    int sel;
    bit [1:0] dirR;
    bit movR;

    for (int i = 0; i < 128; i++) begin
      romModel[i] = (i < 80) ? 17'($urandom) : 17'd0;
    end
    romModel[4][10] = 1'b1;
    romModel[4][15] = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 10'($urandom),
                    10'($urandom), 10'($urandom), 10'($urandom), 1'($urandom));
    end
    checkOutput("reset_frame_sel", 32'(frameSel), 32'd0);
    checkOutput("reset_rom_addr", 32'(romAddr), 32'd0);
    checkOutput("reset_pixel_on", 32'(pixelOn), 32'd0);
    checkOutput("reset_pixel_valid", 32'(pixelValid), 32'd0);

    // Pixel hit tests on the closed frame.
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 10'd100, 10'd200, 10'd105, 10'd204, 1'b1);
    checkOutput("hit_rom_addr", 32'(romAddr), 32'd4);
    checkOutput("hit_no_valid_yet", 32'(pixelValid), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 10'd100, 10'd200, 10'd100, 10'd204, 1'b1);
    checkOutput("hit_pixel_on", 32'(pixelOn), 32'd1);
    checkOutput("hit_first_valid", 32'(pixelValid), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 10'd100, 10'd200, 10'd99, 10'd204, 1'b1);
    checkOutput("col0_pixel_on", 32'(pixelOn), 32'd0);
    checkOutput("left_miss_rom_addr", 32'(romAddr), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 10'd100, 10'd200, 10'd116, 10'd204, 1'b1);
    checkOutput("left_miss_pixel_on", 32'(pixelOn), 32'd0);
    checkOutput("left_miss_pixel_valid", 32'(pixelValid), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 10'd100, 10'd200, 10'd0, 10'd0, 1'b0);
    checkOutput("right_miss_pixel_on", 32'(pixelOn), 32'd0);
    checkOutput("right_miss_pixel_valid", 32'(pixelValid), 32'd1);

    // Animation while moving right.
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b1, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0);
      if (t == 7) checkOutput("anim_tick7", 32'(frameSel), 32'd0);
      if (t == 8) checkOutput("anim_tick8", 32'(frameSel), 32'd4);
      if (t == 16) checkOutput("anim_tick16", 32'(frameSel), 32'd0);
      for (int k = 0; k < 2; k++) begin
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b1, 10'd300, 10'd300,
                      10'(300 + $urandom_range(0, 19)), 10'(300 + $urandom_range(0, 19)),
                      1'($urandom));
      end
    end

    // Stopped facing down.
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0);
    checkOutput("stopped_frame_sel", 32'(frameSel), 32'd2);
    for (int t = 0; t < 20; t++) begin
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0);
    end
    checkOutput("stopped_hold", 32'(frameSel), 32'd2);

    // Direction latch: request changes mid-frame, takes effect on the tick.
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 10'd100, 10'd200, 10'd0, 10'd0, 1'b0);
    checkOutput("latch_open_right", 32'(frameSel), 32'd4);
    applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 10'd100, 10'd200, 10'd100, 10'd200, 1'b1);
    checkOutput("latch_mid_frame", 32'(frameSel), 32'd4);
    checkOutput("latch_inflight_addr", 32'(romAddr), 32'd64);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 10'd100, 10'd200, 10'd103, 10'd201, 1'b1);
    checkOutput("latch_after_tick", 32'(frameSel), 32'd3);
    checkOutput("tick_cycle_addr", 32'(romAddr), 32'd65);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 10'd100, 10'd200, 10'd101, 10'd202, 1'b1);
    checkOutput("new_frame_addr", 32'(romAddr), 32'd50);

    // Reset during a stream of hit pixels.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 10'd100, 10'd200,
                    10'(100 + $urandom_range(0, 15)), 10'(200 + $urandom_range(0, 15)), 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 10'd100, 10'd200, 10'd105, 10'd205, 1'b1);
    checkOutput("midreset_pixel_valid", 32'(pixelValid), 32'd0);
    checkOutput("midreset_pixel_on", 32'(pixelOn), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 10'd100, 10'd200, 10'd105, 10'd205, 1'b0);
    end
    checkOutput("post_reset_quiet", 32'(pixelValid), 32'd0);

    // Randomized traffic including wrap-around positions and random resets.
    px = 500;
    py = 400;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        sel = $urandom_range(0, 3);
        px  = (sel == 0) ? 0 : (sel == 1) ? 1008 : $urandom_range(0, 1008);
        py  = (sel == 2) ? 1008 : $urandom_range(0, 1008);
      end
      dirR = 2'($urandom);
      movR = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), dirR, movR,
                    10'(px), 10'(py),
                    10'((px + $urandom_range(0, 23) - 4) & 1023),
                    10'((py + $urandom_range(0, 23) - 4) & 1023),
                    ($urandom_range(0, 4) != 0));
    end

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
    end
    checkOutput("drain_pixel_queue", 32'(pixQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
